// File: rtl/life_respawn_controller.sv
// Death / respawn / invincibility sequencer for the player, timed in video frames.
// Optional macro EXTRA_LIFE_EN lets one_up give back a life in ALIVE or INVULN.
module life_respawn_controller #(
  parameter int DEATH_FRAMES  = 90,
  parameter int INVULN_FRAMES = 120,
  parameter int CNT_W         = 8,
  parameter int BLINK_BIT     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] state_in,
  input  logic       hit,
  input  logic       fall,
  input  logic       one_up,
  output logic [1:0] lives,
  output logic       freeze,
  output logic       respawn_req,
  output logic       invincible,
  output logic       blink,
  output logic       death_pulse
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALIVE   = 3'd1,
    S_DYING   = 3'd2,
    S_RESPAWN = 3'd3,
    S_INVULN  = 3'd4,
    S_DEAD    = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_lives, w_lives_nxt;
  logic             r_freeze, r_respawn_req, r_invincible, r_blink, r_death_pulse;
  logic             w_freeze_nxt, w_respawn_nxt, w_invincible_nxt, w_blink_nxt;
  logic             w_in_game, w_kill;

  assign w_in_game = (state_in == 2'd1);
  assign w_kill    = w_in_game &&
                     (((r_state == S_ALIVE) && (hit || fall)) ||
                      ((r_state == S_INVULN) && fall));

`ifdef EXTRA_LIFE_EN
  logic w_one_up_dec;
  assign w_one_up_dec = one_up && !w_kill && (r_lives != 2'd0) &&
                        ((r_state == S_ALIVE) || (r_state == S_INVULN));
`else
  logic w_unused_one_up;
  assign w_unused_one_up = one_up;
`endif

  // Next-state, frame counter and lives bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lives_nxt = r_lives;
    if (!w_in_game) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = {CNT_W{1'b0}};
      if ((r_state == S_IDLE) && (state_in == 2'd0)) begin
        w_lives_nxt = 2'd0;
      end else begin
        w_lives_nxt = r_lives;
      end
    end else if (w_kill) begin
      w_state_nxt = S_DYING;
      w_cnt_nxt   = CNT_W'(DEATH_FRAMES);
      if (r_lives != 2'd3) begin
        w_lives_nxt = r_lives + 2'd1;
      end else begin
        w_lives_nxt = r_lives;
      end
    end else begin
`ifdef EXTRA_LIFE_EN
      if (w_one_up_dec) begin
        w_lives_nxt = r_lives - 2'd1;
      end else begin
        w_lives_nxt = r_lives;
      end
`endif
      case (r_state)
        S_IDLE:    w_state_nxt = S_ALIVE;
        S_ALIVE:   w_state_nxt = S_ALIVE;
        S_DYING: begin
          if (frame_tick && (r_cnt == {CNT_W{1'b0}})) begin
            w_state_nxt = (r_lives == 2'd3) ? S_DEAD : S_RESPAWN;
          end else if (frame_tick) begin
            w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        S_RESPAWN: begin
          w_state_nxt = S_INVULN;
          w_cnt_nxt   = CNT_W'(INVULN_FRAMES);
        end
        S_INVULN: begin
          if (frame_tick && (r_cnt == {CNT_W{1'b0}})) begin
            w_state_nxt = S_ALIVE;
          end else if (frame_tick) begin
            w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        S_DEAD:    w_state_nxt = S_DEAD;
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    w_freeze_nxt     = (w_state_nxt == S_DYING) || (w_state_nxt == S_RESPAWN) ||
                       (w_state_nxt == S_DEAD);
    w_respawn_nxt    = (w_state_nxt == S_RESPAWN);
    w_invincible_nxt = (w_state_nxt == S_INVULN);
    w_blink_nxt      = (w_state_nxt == S_INVULN) && w_cnt_nxt[BLINK_BIT];
  end

  // State, counter, lives and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_lives       <= 2'd0;
      r_freeze      <= 1'b0;
      r_respawn_req <= 1'b0;
      r_invincible  <= 1'b0;
      r_blink       <= 1'b0;
      r_death_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_lives       <= w_lives_nxt;
      r_freeze      <= w_freeze_nxt;
      r_respawn_req <= w_respawn_nxt;
      r_invincible  <= w_invincible_nxt;
      r_blink       <= w_blink_nxt;
      r_death_pulse <= w_kill;
    end
  end

  assign lives       = r_lives;
  assign freeze      = r_freeze;
  assign respawn_req = r_respawn_req;
  assign invincible  = r_invincible;
  assign blink       = r_blink;
  assign death_pulse = r_death_pulse;

endmodule

// File: tb/tb_life_respawn_controller.sv
// Directed self-checking bench for life_respawn_controller (default parameters).
module tb_life_respawn_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [1:0] state_in;
  logic       hit, fall, one_up;
  logic [1:0] lives;
  logic       freeze, respawn_req, invincible, blink, death_pulse;

  int checks = 0;
  int errors = 0;

  life_respawn_controller #(
    .DEATH_FRAMES(90), .INVULN_FRAMES(120), .CNT_W(8), .BLINK_BIT(2)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .state_in(state_in),
    .hit(hit), .fall(fall), .one_up(one_up), .lives(lives), .freeze(freeze),
    .respawn_req(respawn_req), .invincible(invincible), .blink(blink),
    .death_pulse(death_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  task automatic pulse_fall();
    fall = 1'b1;
    @(negedge clk);
    fall = 1'b0;
  endtask

  // From DYING (lives < 3) back to ALIVE.
  task automatic recover();
    tick(91);
    step();
    tick(121);
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; state_in = 2'd0;
    hit = 1'b0; fall = 1'b0; one_up = 1'b0;
    step(); step();
    checks++;
    if ({lives, freeze, respawn_req, invincible, blink, death_pulse} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 0000000",
               {lives, freeze, respawn_req, invincible, blink, death_pulse});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_start();
    state_in = 2'd1;
    step();
    checks++;
    if (lives !== 2'd0 || freeze !== 1'b0 || invincible !== 1'b0) begin
      errors++;
      $display("FAIL start lives=%0d freeze=%0d inv=%0d expected 0 0 0", lives, freeze, invincible);
    end
  endtask

  task automatic test_death_sequence();
    pulse_hit();
    checks++;
    if (death_pulse !== 1'b1 || lives !== 2'd1 || freeze !== 1'b1) begin
      errors++;
      $display("FAIL hit_kill dp=%0d lives=%0d freeze=%0d expected 1 1 1", death_pulse, lives, freeze);
    end
    step();
    checks++;
    if (death_pulse !== 1'b0) begin
      errors++;
      $display("FAIL death_pulse_width got %0d expected 0", death_pulse);
    end
    tick(90);
    checks++;
    if (respawn_req !== 1'b0 || freeze !== 1'b1) begin
      errors++;
      $display("FAIL dying_90 rr=%0d freeze=%0d expected 0 1", respawn_req, freeze);
    end
    tick(1);
    checks++;
    if (respawn_req !== 1'b1 || freeze !== 1'b1) begin
      errors++;
      $display("FAIL respawn rr=%0d freeze=%0d expected 1 1", respawn_req, freeze);
    end
    step();
    checks++;
    if (respawn_req !== 1'b0 || invincible !== 1'b1 || freeze !== 1'b0 || blink !== 1'b0) begin
      errors++;
      $display("FAIL invuln_entry rr=%0d inv=%0d freeze=%0d blink=%0d expected 0 1 0 0",
               respawn_req, invincible, freeze, blink);
    end
    tick(1);
    checks++;
    if (blink !== 1'b1) begin
      errors++;
      $display("FAIL blink_119 got %0d expected 1", blink);
    end
    tick(119);
    checks++;
    if (invincible !== 1'b1 || blink !== 1'b0) begin
      errors++;
      $display("FAIL invuln_end inv=%0d blink=%0d expected 1 0", invincible, blink);
    end
    tick(1);
    checks++;
    if (invincible !== 1'b0 || blink !== 1'b0 || freeze !== 1'b0 || lives !== 2'd1) begin
      errors++;
      $display("FAIL back_alive inv=%0d blink=%0d freeze=%0d lives=%0d expected 0 0 0 1",
               invincible, blink, freeze, lives);
    end
  endtask

  task automatic test_invuln_and_game_over();
    pulse_fall();
    checks++;
    if (lives !== 2'd2 || death_pulse !== 1'b1) begin
      errors++;
      $display("FAIL fall_kill lives=%0d dp=%0d expected 2 1", lives, death_pulse);
    end
    tick(91);
    step();
    pulse_hit();
    checks++;
    if (lives !== 2'd2 || death_pulse !== 1'b0 || invincible !== 1'b1) begin
      errors++;
      $display("FAIL invuln_hit lives=%0d dp=%0d inv=%0d expected 2 0 1", lives, death_pulse, invincible);
    end
    pulse_fall();
    checks++;
    if (lives !== 2'd3 || death_pulse !== 1'b1 || freeze !== 1'b1 || invincible !== 1'b0) begin
      errors++;
      $display("FAIL invuln_fall lives=%0d dp=%0d freeze=%0d inv=%0d expected 3 1 1 0",
               lives, death_pulse, freeze, invincible);
    end
    tick(91);
    checks++;
    if (freeze !== 1'b1 || respawn_req !== 1'b0) begin
      errors++;
      $display("FAIL dead freeze=%0d rr=%0d expected 1 0", freeze, respawn_req);
    end
    tick(3);
    checks++;
    if (freeze !== 1'b1 || respawn_req !== 1'b0 || lives !== 2'd3) begin
      errors++;
      $display("FAIL dead_hold freeze=%0d rr=%0d lives=%0d expected 1 0 3", freeze, respawn_req, lives);
    end
    state_in = 2'd2;
    step(); step();
    checks++;
    if (lives !== 2'd3 || freeze !== 1'b0) begin
      errors++;
      $display("FAIL game_over_hold lives=%0d freeze=%0d expected 3 0", lives, freeze);
    end
    state_in = 2'd0;
    step();
    checks++;
    if (lives !== 2'd0) begin
      errors++;
      $display("FAIL start_clear lives=%0d expected 0", lives);
    end
  endtask

  task automatic test_same_cycle_and_reset();
    state_in = 2'd1;
    step();
    hit = 1'b1; fall = 1'b1; frame_tick = 1'b1;
    step();
    hit = 1'b0; fall = 1'b0; frame_tick = 1'b0;
    checks++;
    if (lives !== 2'd1 || death_pulse !== 1'b1) begin
      errors++;
      $display("FAIL hit_fall_same lives=%0d dp=%0d expected 1 1", lives, death_pulse);
    end
    tick(90);
    checks++;
    if (respawn_req !== 1'b0) begin
      errors++;
      $display("FAIL kill_tick_no_dec rr=%0d expected 0", respawn_req);
    end
    tick(1);
    checks++;
    if (respawn_req !== 1'b1) begin
      errors++;
      $display("FAIL kill_tick_respawn rr=%0d expected 1", respawn_req);
    end
    step();
    pulse_fall();
    tick(10);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({lives, freeze, respawn_req, invincible, blink, death_pulse} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got %b expected 0000000",
               {lives, freeze, respawn_req, invincible, blink, death_pulse});
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if (respawn_req !== 1'b0 || death_pulse !== 1'b0 || lives !== 2'd0 || freeze !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rr=%0d dp=%0d lives=%0d freeze=%0d expected 0 0 0 0",
               respawn_req, death_pulse, lives, freeze);
    end
  endtask

  task automatic test_extra_life();
    pulse_hit();
    recover();
`ifdef EXTRA_LIFE_EN
    pulse_hit();
    recover();
    one_up = 1'b1; step(); one_up = 1'b0;
    checks++;
    if (lives !== 2'd1) begin
      errors++;
      $display("FAIL one_up_dec lives=%0d expected 1", lives);
    end
    one_up = 1'b1; step(); step(); one_up = 1'b0;
    checks++;
    if (lives !== 2'd0) begin
      errors++;
      $display("FAIL one_up_sat lives=%0d expected 0", lives);
    end
    one_up = 1'b1; hit = 1'b1; step(); one_up = 1'b0; hit = 1'b0;
    checks++;
    if (lives !== 2'd1 || death_pulse !== 1'b1) begin
      errors++;
      $display("FAIL one_up_vs_kill lives=%0d dp=%0d expected 1 1", lives, death_pulse);
    end
`else
    one_up = 1'b1; step(); step(); one_up = 1'b0;
    checks++;
    if (lives !== 2'd1) begin
      errors++;
      $display("FAIL one_up_ignored lives=%0d expected 1", lives);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_start();
    test_death_sequence();
    test_invuln_and_game_over();
    test_same_cycle_and_reset();
    test_extra_life();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
